score_evaluator_multi: RTL and testbench
========================================

Name: score_evaluator_multi

Overview:
- Parametrised whack-a-mole score evaluator that supports N holes and several moles up at once.
- Scores each mole appearance at most once.
- Adds a streak bonus, a selectable wrong-guess penalty (lockout or score deduction) and a retained high score.
- Sits between the button-decode/debounce logic (eval_now, user_guess) and the mole generator (mole_mask, mole_change). Drives the score display and the LED feedback.

Parameters:
NUM_HOLES, 8, number of mole holes; valid guess indices are 0..NUM_HOLES-1
GUESS_W, 3, width of user_guess; 2^GUESS_W >= NUM_HOLES
SCORE_W, 8, width of score and high_score
STREAK_W, 4, width of streak counter
STREAK_BONUS_AT, 3, streak value at or above which a hit scores +2 instead of +1
PENALTY_MODE, 0, 0 = lockout for BLOCK_CYCLES; 1 = score decrement, no lockout
BLOCK_CYCLES, 100000000, lockout length in clk cycles (>=1)
CNT_W, 27, lockout counter width; 2^CNT_W >= BLOCK_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset; clears all state including high_score
i_restart_game  in  1  synchronous new-game request; level, sampled every cycle
i_game_over  in  1  synchronous game-over level from timer
eval_now  in  1  one-cycle pulse: a guess is presented on user_guess
user_guess  in  GUESS_W  hole index pressed
mole_mask  in  NUM_HOLES  bit i = mole currently up in hole i
mole_change  in  1  one-cycle pulse: mole set is being replaced
score  out  SCORE_W  current score
high_score  out  SCORE_W  best final score since rst
streak  out  STREAK_W  consecutive correct hits
guess_correct  out  1  one-cycle pulse, hit accepted
guess_wrong  out  1  one-cycle pulse, miss penalised
guess_now  out  1  high when a guess will be evaluated
blocked  out  1  high during lockout

Behaviour:
- Reset values (rst): score=0, high_score=0, streak=0, hit_mask=0, state=PLAY, counter=0, guess_correct=0, guess_wrong=0, guess_now=1, blocked=0.
- All outputs are registered. The result of a guess appears in the cycle after eval_now is sampled (latency 1). Result pulses are exactly 1 cycle wide.
- States are PLAY, BLOCKED and OVER. Priority order each cycle: i_restart_game > i_game_over > state logic.
- Restart: i_restart_game=1, from any state. Sets score=0, streak=0, hit_mask=0, counter=0, state=PLAY, guess_now=1, pulses=0. high_score is retained.
- Game over: i_game_over=1 and no restart. State goes to OVER; guess_now=0, blocked=0, pulses=0, and score holds. If score > high_score, high_score is set to score on OVER entry. OVER persists until restart; eval_now is ignored.
- Classification in PLAY when eval_now=1, with idx=user_guess:
  - Hit: idx<NUM_HOLES, mole_mask[idx]=1, hit_mask[idx]=0.
  - Repeat: idx<NUM_HOLES, mole_mask[idx]=1, hit_mask[idx]=1.
  - Miss: otherwise, including idx>=NUM_HOLES.
- Hit:
  - score += (streak>=STREAK_BONUS_AT ? 2 : 1), saturating at 2^SCORE_W-1.
  - streak += 1, saturating at 2^STREAK_W-1.
  - hit_mask[idx] is set and guess_correct pulses.
- Repeat: no change to any output. No pulse is generated and streak is not affected.
- Miss: streak=0 and guess_wrong pulses.
  - PENALTY_MODE=0: enter BLOCKED with counter=0; guess_now=0 and blocked=1 starting the next cycle.
  - PENALTY_MODE=1: score -= 1, saturating at 0. State stays PLAY.
- BLOCKED:
  - eval_now is ignored.
  - counter increments each cycle. When counter==BLOCK_CYCLES-1, go to PLAY with guess_now=1 and blocked=0.
  - guess_now is therefore low for exactly BLOCK_CYCLES cycles.
- mole_change clears hit_mask in any state.
  - If it coincides with eval_now, the guess is classified against the pre-clear hit_mask and the current mole_mask. The clear then wins over any bit set by that hit.
- mole_mask may change at any time. Classification uses its value in the eval_now cycle.
- rst asserted mid-lockout or mid-game returns immediately to the reset values.

Test Plan:
(Parameters NUM_HOLES=6, GUESS_W=3, BLOCK_CYCLES=4, STREAK_BONUS_AT=3, SCORE_W=8 unless noted.)
- Streak bonus: mole_mask=6'b000100, mole_change pulse before each hit, four hits with guess 2 -> score 1,2,3,5; streak 1,2,3,4; guess_correct pulses 1 cycle after each eval_now.
- Repeat and out-of-range:
  - Hit on guess 2, then guess 2 again with no mole_change -> score unchanged, no pulses.
  - Guess 7 -> guess_wrong pulse, streak=0.
- Lockout, PENALTY_MODE=0: miss -> guess_now=0 and blocked=1 for exactly 4 cycles; eval_now during those cycles causes no score change or pulse; guess_now=1 on cycle 5.
- Deduction, PENALTY_MODE=1: score=1, two misses -> score 1->0->0; no lockout; guess_now stays 1.
- Simultaneous and saturating events:
  - eval_now on an unhit mole together with mole_change -> hit counted, hit_mask=0 afterwards.
  - SCORE_W=4, score=15, hit -> score stays 15.
- Game over and high score:
  - score=5, i_game_over -> high_score=5, guess_now=0.
  - Restart, score 3, game over -> high_score stays 5.
  - Restart and game_over asserted together -> state PLAY.
  - rst -> high_score=0.

Source files
------------

// File: rtl/score_evaluator_multi_if.sv
// score_evaluator_multi_if
// Groups every game-side signal of the score evaluator into one bundle.
//   master : drives the game inputs (restart, game over, guess, mole set)
//            and observes the evaluator outputs.
//   slave  : the evaluator itself; consumes the inputs and drives the
//            score, high score, streak, result pulses and lockout status.
// Signals:
//   i_restart_game, i_game_over   game control levels
//   eval_now, user_guess          guess strobe and hole index
//   mole_mask, mole_change        moles currently up, mole-set replacement
//   score, high_score, streak     counters shown on the display
//   guess_correct, guess_wrong    one-cycle result pulses
//   guess_now, blocked            guess acceptance / lockout indicators
interface score_evaluator_multi_if #(
   parameter int NUM_HOLES = 8,
   parameter int GUESS_W   = 3,
   parameter int SCORE_W   = 8,
   parameter int STREAK_W  = 4
);
   logic                 i_restart_game;
   logic                 i_game_over;
   logic                 eval_now;
   logic [GUESS_W-1:0]   user_guess;
   logic [NUM_HOLES-1:0] mole_mask;
   logic                 mole_change;
   logic [SCORE_W-1:0]   score;
   logic [SCORE_W-1:0]   high_score;
   logic [STREAK_W-1:0]  streak;
   logic                 guess_correct;
   logic                 guess_wrong;
   logic                 guess_now;
   logic                 blocked;

   modport master (
      output i_restart_game, i_game_over, eval_now, user_guess, mole_mask, mole_change,
      input  score, high_score, streak, guess_correct, guess_wrong, guess_now, blocked
   );

   modport slave (
      input  i_restart_game, i_game_over, eval_now, user_guess, mole_mask, mole_change,
      output score, high_score, streak, guess_correct, guess_wrong, guess_now, blocked
   );
endinterface

// File: rtl/score_evaluator_multi.sv
// score_evaluator_multi
// Whack-a-mole score evaluator for NUM_HOLES holes with several moles up at
// once. Each mole appearance is scored at most once (tracked in hit_mask,
// cleared whenever the mole set is replaced). Hits earn +1, or +2 once the
// streak reaches STREAK_BONUS_AT. A miss resets the streak and either locks
// guessing out for BLOCK_CYCLES cycles (PENALTY_MODE=0) or costs one point
// (PENALTY_MODE=1). The best final score is kept until rst.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset, clears everything incl. high_score
//   bus  score_evaluator_multi_if slave modport (game inputs, all outputs)
// All outputs are registered; a guess result appears one cycle after eval_now.
module score_evaluator_multi #(
   parameter int NUM_HOLES       = 8,
   parameter int GUESS_W         = 3,
   parameter int SCORE_W         = 8,
   parameter int STREAK_W        = 4,
   parameter int STREAK_BONUS_AT = 3,
   parameter int PENALTY_MODE    = 0,
   parameter int BLOCK_CYCLES    = 100000000,
   parameter int CNT_W           = 27
) (
   input logic                     clk,
   input logic                     rst,
   score_evaluator_multi_if.slave  bus
);

   typedef enum logic [1:0] {PLAY, BLOCKED, OVER} state_t;

   localparam logic [SCORE_W-1:0]  SCORE_MAX  = '1;
   localparam logic [STREAK_W-1:0] STREAK_MAX = '1;
   localparam logic [STREAK_W:0]   BONUS_AT   = (STREAK_W+1)'(STREAK_BONUS_AT);
   localparam logic [CNT_W-1:0]    COUNT_LAST = CNT_W'(BLOCK_CYCLES - 1);

   state_t               state_r, state_nxt;
   logic [SCORE_W-1:0]   score_r, score_nxt;
   logic [SCORE_W-1:0]   high_r, high_nxt;
   logic [STREAK_W-1:0]  streak_r, streak_nxt;
   logic [NUM_HOLES-1:0] hit_mask_r, hit_mask_nxt;
   logic [CNT_W-1:0]     count_r, count_nxt;
   logic                 correct_r, correct_nxt;
   logic                 wrong_r, wrong_nxt;
   logic                 guess_now_r, guess_now_nxt;
   logic                 blocked_r, blocked_nxt;

   logic [NUM_HOLES-1:0] guess_onehot;
   logic                 is_hit;
   logic                 is_repeat;
   logic [SCORE_W:0]     score_sum;

   // Decode the guess into a one-hot hole vector; indices at or above
   // NUM_HOLES decode to all zeros and therefore always classify as a miss.
   always_comb begin
      guess_onehot = '0;
      for (int i = 0; i < NUM_HOLES; i++) begin
         if (bus.user_guess == GUESS_W'(i)) guess_onehot[i] = 1'b1;
      end
   end

   assign is_hit    = |(guess_onehot & bus.mole_mask & ~hit_mask_r);
   assign is_repeat = |(guess_onehot & bus.mole_mask & hit_mask_r);

   // One extra bit catches overflow so the hit reward can saturate.
   assign score_sum = {1'b0, score_r} +
                      (({1'b0, streak_r} >= BONUS_AT) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));

   // Next-state logic: restart beats game over, which beats normal play.
   // A mole change clears hit_mask last so it overrides a bit set by a
   // simultaneous hit.
   always_comb begin
      state_nxt     = state_r;
      score_nxt     = score_r;
      high_nxt      = high_r;
      streak_nxt    = streak_r;
      hit_mask_nxt  = hit_mask_r;
      count_nxt     = count_r;
      correct_nxt   = 1'b0;
      wrong_nxt     = 1'b0;
      guess_now_nxt = guess_now_r;
      blocked_nxt   = blocked_r;

      if (bus.i_restart_game) begin
         state_nxt     = PLAY;
         score_nxt     = '0;
         streak_nxt    = '0;
         hit_mask_nxt  = '0;
         count_nxt     = '0;
         guess_now_nxt = 1'b1;
         blocked_nxt   = 1'b0;
      end else if (bus.i_game_over) begin
         state_nxt     = OVER;
         guess_now_nxt = 1'b0;
         blocked_nxt   = 1'b0;
         if (score_r > high_r) high_nxt = score_r;
      end else begin
         case (state_r)
            PLAY: begin
               if (bus.eval_now) begin
                  if (is_hit) begin
                     score_nxt    = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
                     streak_nxt   = (streak_r == STREAK_MAX) ? STREAK_MAX : streak_r + 1'b1;
                     hit_mask_nxt = hit_mask_r | guess_onehot;
                     correct_nxt  = 1'b1;
                  end else if (!is_repeat) begin
                     streak_nxt = '0;
                     wrong_nxt  = 1'b1;
                     if (PENALTY_MODE == 0) begin
                        state_nxt     = BLOCKED;
                        count_nxt     = '0;
                        guess_now_nxt = 1'b0;
                        blocked_nxt   = 1'b1;
                     end else if (score_r != '0) begin
                        score_nxt = score_r - 1'b1;
                     end
                  end
               end
            end
            BLOCKED: begin
               if (count_r == COUNT_LAST) begin
                  state_nxt     = PLAY;
                  count_nxt     = '0;
                  guess_now_nxt = 1'b1;
                  blocked_nxt   = 1'b0;
               end else begin
                  count_nxt = count_r + 1'b1;
               end
            end
            default: begin
               state_nxt = OVER;
            end
         endcase
      end

      if (bus.mole_change) hit_mask_nxt = '0;
   end

   // State register; guess_now comes out of reset high because play starts
   // immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= PLAY;
         score_r     <= '0;
         high_r      <= '0;
         streak_r    <= '0;
         hit_mask_r  <= '0;
         count_r     <= '0;
         correct_r   <= 1'b0;
         wrong_r     <= 1'b0;
         guess_now_r <= 1'b1;
         blocked_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         score_r     <= score_nxt;
         high_r      <= high_nxt;
         streak_r    <= streak_nxt;
         hit_mask_r  <= hit_mask_nxt;
         count_r     <= count_nxt;
         correct_r   <= correct_nxt;
         wrong_r     <= wrong_nxt;
         guess_now_r <= guess_now_nxt;
         blocked_r   <= blocked_nxt;
      end
   end

   assign bus.score         = score_r;
   assign bus.high_score    = high_r;
   assign bus.streak        = streak_r;
   assign bus.guess_correct = correct_r;
   assign bus.guess_wrong   = wrong_r;
   assign bus.guess_now     = guess_now_r;
   assign bus.blocked       = blocked_r;

endmodule

// File: tb/tb_score_evaluator_multi.sv
// tb_score_evaluator_multi
// Directed bench for score_evaluator_multi with two instances:
//   dut_a : lockout penalty, 8-bit score, 4-cycle lockout
//   dut_b : deduction penalty, 4-bit score (saturation corner)
// Both use 6 holes and a 3-bit guess so out-of-range indices can be driven.
module tb_score_evaluator_multi;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   score_evaluator_multi_if #(.NUM_HOLES(6), .GUESS_W(3), .SCORE_W(8), .STREAK_W(4)) ifa ();
   score_evaluator_multi_if #(.NUM_HOLES(6), .GUESS_W(3), .SCORE_W(4), .STREAK_W(4)) ifb ();

   score_evaluator_multi #(
      .NUM_HOLES(6), .GUESS_W(3), .SCORE_W(8), .STREAK_W(4), .STREAK_BONUS_AT(3),
      .PENALTY_MODE(0), .BLOCK_CYCLES(4), .CNT_W(3)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   score_evaluator_multi #(
      .NUM_HOLES(6), .GUESS_W(3), .SCORE_W(4), .STREAK_W(4), .STREAK_BONUS_AT(3),
      .PENALTY_MODE(1), .BLOCK_CYCLES(4), .CNT_W(3)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   always #5 clk = ~clk;

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs into the selected instance (0 = a, 1 = b),
   // clocks once, then samples 1 time unit after the edge and drops all
   // strobes and control levels.
   task automatic applyStimulus(input bit sel, input logic ev, input logic [2:0] g,
                                input logic [5:0] m, input logic mc,
                                input logic rs, input logic go);
      if (!sel) begin
         ifa.eval_now = ev; ifa.user_guess = g; ifa.mole_mask = m;
         ifa.mole_change = mc; ifa.i_restart_game = rs; ifa.i_game_over = go;
      end else begin
         ifb.eval_now = ev; ifb.user_guess = g; ifb.mole_mask = m;
         ifb.mole_change = mc; ifb.i_restart_game = rs; ifb.i_game_over = go;
      end
      @(posedge clk);
      #1;
      ifa.eval_now = 1'b0; ifa.mole_change = 1'b0; ifa.i_restart_game = 1'b0; ifa.i_game_over = 1'b0;
      ifb.eval_now = 1'b0; ifb.mole_change = 1'b0; ifb.i_restart_game = 1'b0; ifb.i_game_over = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int exp_score[4];
      logic [5:0] m;
      exp_score = '{1, 2, 3, 5};
      m = 6'b000100;

      ifa.eval_now = 0; ifa.user_guess = 0; ifa.mole_mask = 0; ifa.mole_change = 0;
      ifa.i_restart_game = 0; ifa.i_game_over = 0;
      ifb.eval_now = 0; ifb.user_guess = 0; ifb.mole_mask = 0; ifb.mole_change = 0;
      ifb.i_restart_game = 0; ifb.i_game_over = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_score",     ifa.score, 0);
      checkOutput("rst_high",      ifa.high_score, 0);
      checkOutput("rst_streak",    ifa.streak, 0);
      checkOutput("rst_correct",   ifa.guess_correct, 0);
      checkOutput("rst_wrong",     ifa.guess_wrong, 0);
      checkOutput("rst_guess_now", ifa.guess_now, 1);
      checkOutput("rst_blocked",   ifa.blocked, 0);
      checkOutput("rst_b_score",   ifb.score, 0);
      @(negedge clk);
      rst = 1'b0;

      // Deduction mode: hit then two misses, score 1 -> 0 -> 0, no lockout
      applyStimulus(1, 1, 3'd1, 6'b000010, 1, 0, 0);
      checkOutput("b_hit_score",   ifb.score, 1);
      checkOutput("b_hit_correct", ifb.guess_correct, 1);
      applyStimulus(1, 1, 3'd0, 6'b000010, 0, 0, 0);
      checkOutput("b_miss1_score", ifb.score, 0);
      checkOutput("b_miss1_wrong", ifb.guess_wrong, 1);
      checkOutput("b_miss1_streak", ifb.streak, 0);
      checkOutput("b_miss1_gnow",  ifb.guess_now, 1);
      checkOutput("b_miss1_blk",   ifb.blocked, 0);
      applyStimulus(1, 1, 3'd0, 6'b000010, 0, 0, 0);
      checkOutput("b_miss2_score", ifb.score, 0);
      checkOutput("b_miss2_wrong", ifb.guess_wrong, 1);
      checkOutput("b_miss2_gnow",  ifb.guess_now, 1);

      // Saturation on 4-bit score: 1,2,3,5,7,9,11,13,15 then stays 15
      for (int k = 0; k < 9; k++) applyStimulus(1, 1, 3'd1, 6'b000010, 1, 0, 0);
      checkOutput("b_nine_hits_score",  ifb.score, 15);
      checkOutput("b_nine_hits_streak", ifb.streak, 9);
      applyStimulus(1, 1, 3'd1, 6'b000010, 1, 0, 0);
      checkOutput("b_sat_score",   ifb.score, 15);
      checkOutput("b_sat_correct", ifb.guess_correct, 1);
      checkOutput("b_sat_streak",  ifb.streak, 10);
      applyStimulus(1, 1, 3'd6, 6'b111111, 0, 0, 0);
      checkOutput("b_oor_wrong",  ifb.guess_wrong, 1);
      checkOutput("b_oor_score",  ifb.score, 14);
      checkOutput("b_oor_streak", ifb.streak, 0);

      // Streak bonus on instance a
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 3'd0, m, 1, 0, 0);
         checkOutput("a_mc_correct_low", ifa.guess_correct, 0);
         applyStimulus(0, 1, 3'd2, m, 0, 0, 0);
         checkOutput("a_bonus_score",   ifa.score, exp_score[k]);
         checkOutput("a_bonus_streak",  ifa.streak, k + 1);
         checkOutput("a_bonus_correct", ifa.guess_correct, 1);
         checkOutput("a_bonus_wrong",   ifa.guess_wrong, 0);
      end

      // Repeat guess on an already-hit mole
      applyStimulus(0, 0, 3'd0, m, 1, 0, 0);
      applyStimulus(0, 1, 3'd2, m, 0, 0, 0);
      checkOutput("a_hit5_score", ifa.score, 7);
      applyStimulus(0, 1, 3'd2, m, 0, 0, 0);
      checkOutput("a_rep_score",   ifa.score, 7);
      checkOutput("a_rep_streak",  ifa.streak, 5);
      checkOutput("a_rep_correct", ifa.guess_correct, 0);
      checkOutput("a_rep_wrong",   ifa.guess_wrong, 0);

      // Out-of-range guess: miss, lockout for exactly 4 cycles
      applyStimulus(0, 1, 3'd7, m, 0, 0, 0);
      checkOutput("a_oor_wrong",  ifa.guess_wrong, 1);
      checkOutput("a_oor_streak", ifa.streak, 0);
      checkOutput("a_lock0_gnow", ifa.guess_now, 0);
      checkOutput("a_lock0_blk",  ifa.blocked, 1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 3'd2, m, 1, 0, 0);
         checkOutput("a_lock_gnow",    ifa.guess_now, 0);
         checkOutput("a_lock_blk",     ifa.blocked, 1);
         checkOutput("a_lock_score",   ifa.score, 7);
         checkOutput("a_lock_correct", ifa.guess_correct, 0);
         checkOutput("a_lock_wrong",   ifa.guess_wrong, 0);
      end
      applyStimulus(0, 0, 3'd0, m, 0, 0, 0);
      checkOutput("a_unlock_gnow", ifa.guess_now, 1);
      checkOutput("a_unlock_blk",  ifa.blocked, 0);

      // Hit coinciding with mole_change: counted, and hit_mask ends clear
      applyStimulus(0, 1, 3'd2, m, 1, 0, 0);
      checkOutput("a_sim_score",   ifa.score, 8);
      checkOutput("a_sim_correct", ifa.guess_correct, 1);
      applyStimulus(0, 1, 3'd2, m, 0, 0, 0);
      checkOutput("a_after_sim_score",   ifa.score, 9);
      checkOutput("a_after_sim_correct", ifa.guess_correct, 1);
      checkOutput("a_after_sim_streak",  ifa.streak, 2);

      // Game over captures high score; guesses ignored
      applyStimulus(0, 0, 3'd0, m, 0, 0, 1);
      checkOutput("a_over_high",  ifa.high_score, 9);
      checkOutput("a_over_score", ifa.score, 9);
      checkOutput("a_over_gnow",  ifa.guess_now, 0);
      checkOutput("a_over_blk",   ifa.blocked, 0);
      applyStimulus(0, 1, 3'd2, m, 1, 0, 1);
      checkOutput("a_over_ign_score",   ifa.score, 9);
      checkOutput("a_over_ign_correct", ifa.guess_correct, 0);

      // Restart keeps high score; a lower final score does not replace it
      applyStimulus(0, 0, 3'd0, m, 0, 1, 0);
      checkOutput("a_restart_score",  ifa.score, 0);
      checkOutput("a_restart_streak", ifa.streak, 0);
      checkOutput("a_restart_high",   ifa.high_score, 9);
      checkOutput("a_restart_gnow",   ifa.guess_now, 1);
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 3'd2, m, 1, 0, 0);
      checkOutput("a_game2_score", ifa.score, 3);
      applyStimulus(0, 0, 3'd0, m, 0, 0, 1);
      checkOutput("a_over2_high",  ifa.high_score, 9);
      checkOutput("a_over2_score", ifa.score, 3);

      // Restart and game over together: restart wins
      applyStimulus(0, 0, 3'd0, m, 0, 1, 1);
      checkOutput("a_both_gnow",  ifa.guess_now, 1);
      checkOutput("a_both_score", ifa.score, 0);
      applyStimulus(0, 1, 3'd2, m, 1, 0, 0);
      checkOutput("a_both_play_score", ifa.score, 1);
      checkOutput("a_both_play_gnow",  ifa.guess_now, 1);

      // Asynchronous reset mid-lockout
      applyStimulus(0, 1, 3'd5, m, 0, 0, 0);
      checkOutput("a_miss5_blk", ifa.blocked, 1);
      rst = 1'b1;
      #1;
      checkOutput("a_arst_blk",   ifa.blocked, 0);
      checkOutput("a_arst_gnow",  ifa.guess_now, 1);
      checkOutput("a_arst_high",  ifa.high_score, 0);
      checkOutput("a_arst_score", ifa.score, 0);
      checkOutput("b_arst_score", ifb.score, 0);
      @(negedge clk);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
